// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO, store-and-forward or cut-through; 2-cycle accept-to-visible latency.
// s_tready derives from registered state only; oversize store-and-forward packets are dropped.
module axis_pkt_fifo #(
  parameter int DW = 8,
  parameter int DD = 2048,
  parameter bit SF_MODE = 1'b1,
  localparam int LW = $clog2(DD) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [LW-1:0] level,
  output logic [LW-1:0] pkt_count,
  output logic          drop
);

  localparam int AW = LW - 1;

  typedef enum logic {ACCEPT, DROP} wstate_t;

  logic [DW:0]   mem [DD];
  logic [LW-1:0] wr_ptr, wr_commit, wr_vis, rd_ptr, pkt_cnt;
  logic          out_vld, out_lst, rdy_en, drop_q;
  logic [DW-1:0] out_dat;
  wstate_t       state;

  logic s_acc, wr_en, m_acc, pop, go_drop, cnt_inc, cnt_dec;

  // The output register is part of the capacity, so it is counted in level.
  assign level    = wr_ptr - rd_ptr + LW'(out_vld);
  assign s_tready = rdy_en && ((state == DROP) || (level < LW'(DD)));
  assign s_acc    = s_tvalid && s_tready;
  assign wr_en    = s_acc && (state == ACCEPT);
  assign m_acc    = out_vld && m_tready;
  assign pop      = (rd_ptr != wr_vis) && (!out_vld || m_tready);
  // Full with no complete packet stored: the partial packet can never drain.
  assign go_drop  = SF_MODE && (state == ACCEPT) && s_tvalid &&
                    (level == LW'(DD)) && (pkt_cnt == '0);
  assign cnt_inc  = wr_en && s_tlast;
  assign cnt_dec  = m_acc && out_lst;

  assign m_tdata   = out_dat;
  assign m_tvalid  = out_vld;
  assign m_tlast   = out_lst;
  assign pkt_count = pkt_cnt;
  assign drop      = drop_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
      wr_vis    <= '0;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
      out_vld   <= 1'b0;
      out_lst   <= 1'b0;
      out_dat   <= '0;
      rdy_en    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      drop_q <= 1'b0;
      case (state)
        ACCEPT: begin
          if (go_drop) begin
            state  <= DROP;
            wr_ptr <= wr_commit;
            drop_q <= 1'b1;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + LW'(1);
            if (s_tlast) wr_commit <= wr_ptr + LW'(1);
          end
        end
        DROP: begin
          if (s_acc && s_tlast) state <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase

      // Lagging copy of the visible limit gives the second cycle of latency.
      wr_vis <= SF_MODE ? wr_commit : wr_ptr;

      if (pop) begin
        {out_lst, out_dat} <= mem[rd_ptr[AW-1:0]];
        out_vld            <= 1'b1;
        rd_ptr             <= rd_ptr + LW'(1);
      end else if (m_acc) begin
        out_vld <= 1'b0;
      end

      if (cnt_inc && !cnt_dec)      pkt_cnt <= pkt_cnt + LW'(1);
      else if (cnt_dec && !cnt_inc) pkt_cnt <= pkt_cnt - LW'(1);
    end
  end

endmodule
